// File: rtl/du_dump_serializer.sv
// Debug dump engine: on i_start it streams PC, RB[0..] and DM[0..] LSB-first to the debug UART.
// Define DUMP_CHECKSUM_EN to append one XOR-of-all-bytes trailer byte after the last DM byte.
module du_dump_serializer #(
    parameter int BYTE        = 8,
    parameter int DWORD       = 32,
    parameter int RB_ADDR     = 5,
    parameter int DM_ADDR     = 5,
    parameter int NB_RB_WORDS = 32,
    parameter int NB_DM_WORDS = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [DWORD-1:0]   i_pc_value,
    input  logic [DWORD-1:0]   i_rb_data,
    input  logic [DWORD-1:0]   i_dm_data,
    input  logic               i_tx_done,
    output logic [RB_ADDR-1:0] o_rb_addr,
    output logic               o_rb_read_enable,
    output logic [DM_ADDR-1:0] o_dm_addr,
    output logic               o_dm_read_enable,
    output logic               o_dm_du_flag,
    output logic [BYTE-1:0]    o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_done
);
    localparam int NB_BYTES = DWORD / BYTE;
    localparam int BI_W     = $clog2(NB_BYTES);
    localparam logic [BI_W-1:0]  LAST_BYTE = BI_W'(NB_BYTES - 1);
    localparam logic [RB_ADDR:0] RB_END    = (RB_ADDR + 1)'(NB_RB_WORDS);
    localparam logic [DM_ADDR:0] DM_END    = (DM_ADDR + 1)'(NB_DM_WORDS);

    typedef enum logic [3:0] {
        IDLE, SEND_PC, RB_REQ, RB_WAIT, DM_REQ, DM_WAIT, SEND_BYTE, WAIT_TX, DONE
    } state_t;

    typedef enum logic [1:0] {PH_PC, PH_RB, PH_DM, PH_CK} phase_t;

    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    logic [DWORD-1:0]   word_q, word_d;
    logic [BI_W-1:0]    byte_idx_q, byte_idx_d;
    logic [RB_ADDR:0]   rb_cnt_q, rb_cnt_d;
    logic [DM_ADDR:0]   dm_cnt_q, dm_cnt_d;
    logic [RB_ADDR-1:0] rb_addr_q, rb_addr_d;
    logic [DM_ADDR-1:0] dm_addr_q, dm_addr_d;
    logic               dm_flag_q, dm_flag_d;
    logic [BYTE-1:0]    tx_data_q, tx_data_d;
    logic [BYTE-1:0]    cur_byte;
`ifdef DUMP_CHECKSUM_EN
    logic [BYTE-1:0]    csum_q, csum_d;
`endif

    assign cur_byte = word_q[int'(byte_idx_q) * BYTE +: BYTE];

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            phase_q    <= PH_PC;
            word_q     <= '0;
            byte_idx_q <= '0;
            rb_cnt_q   <= '0;
            dm_cnt_q   <= '0;
            rb_addr_q  <= '0;
            dm_addr_q  <= '0;
            dm_flag_q  <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            rb_cnt_q   <= rb_cnt_d;
            dm_cnt_q   <= dm_cnt_d;
            rb_addr_q  <= rb_addr_d;
            dm_addr_q  <= dm_addr_d;
            dm_flag_q  <= dm_flag_d;
            tx_data_q  <= tx_data_d;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        rb_cnt_d   = rb_cnt_q;
        dm_cnt_d   = dm_cnt_q;
        rb_addr_d  = rb_addr_q;
        dm_addr_d  = dm_addr_q;
        dm_flag_d  = dm_flag_q;
        tx_data_d  = tx_data_q;
`ifdef DUMP_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    word_d     = i_pc_value;
                    phase_d    = PH_PC;
                    byte_idx_d = '0;
                    rb_cnt_d   = '0;
                    dm_cnt_d   = '0;
`ifdef DUMP_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    state_d    = SEND_BYTE;
                end
            end
            SEND_BYTE: begin
                tx_data_d = cur_byte;
`ifdef DUMP_CHECKSUM_EN
                if (phase_q != PH_CK) begin
                    csum_d = csum_q ^ cur_byte;
                end
`endif
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    if (phase_q != PH_CK && byte_idx_q != LAST_BYTE) begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = SEND_BYTE;
                    end else begin
                        byte_idx_d = '0;
                        // Word finished: pick the next source, or the end of the stream.
                        case (phase_q)
                            PH_PC: begin
                                phase_d   = PH_RB;
                                rb_addr_d = rb_cnt_q[RB_ADDR-1:0];
                                state_d   = RB_REQ;
                            end
                            PH_RB: begin
                                if (rb_cnt_q == RB_END) begin
                                    phase_d   = PH_DM;
                                    dm_addr_d = dm_cnt_q[DM_ADDR-1:0];
                                    dm_flag_d = 1'b1;
                                    state_d   = DM_REQ;
                                end else begin
                                    rb_addr_d = rb_cnt_q[RB_ADDR-1:0];
                                    state_d   = RB_REQ;
                                end
                            end
                            PH_DM: begin
                                if (dm_cnt_q == DM_END) begin
`ifdef DUMP_CHECKSUM_EN
                                    word_d    = DWORD'(csum_q);
                                    phase_d   = PH_CK;
                                    state_d   = SEND_BYTE;
`else
                                    dm_flag_d = 1'b0;
                                    state_d   = DONE;
`endif
                                end else begin
                                    dm_addr_d = dm_cnt_q[DM_ADDR-1:0];
                                    state_d   = DM_REQ;
                                end
                            end
                            default: begin
                                dm_flag_d = 1'b0;
                                state_d   = DONE;
                            end
                        endcase
                    end
                end
            end
            RB_REQ:  state_d = RB_WAIT;
            RB_WAIT: begin
                word_d   = i_rb_data;
                rb_cnt_d = rb_cnt_q + 1'b1;
                state_d  = SEND_BYTE;
            end
            DM_REQ:  state_d = DM_WAIT;
            DM_WAIT: begin
                word_d   = i_dm_data;
                dm_cnt_d = dm_cnt_q + 1'b1;
                state_d  = SEND_BYTE;
            end
            DONE:    state_d = IDLE;
            SEND_PC: state_d = SEND_BYTE;
            default: state_d = IDLE;
        endcase
    end

    assign o_rb_addr        = rb_addr_q;
    assign o_dm_addr        = dm_addr_q;
    assign o_rb_read_enable = (state_q == RB_REQ);
    assign o_dm_read_enable = (state_q == DM_REQ);
    assign o_dm_du_flag     = dm_flag_q;
    assign o_tx_start       = (state_q == SEND_BYTE);
    // The byte is presented together with tx_start, then held from the register.
    assign o_tx_data        = (state_q == SEND_BYTE) ? cur_byte : tx_data_q;
    assign o_busy           = (state_q != IDLE) && (state_q != DONE);
    assign o_done           = (state_q == DONE);

endmodule

// File: tb/tb_du_dump_serializer.sv
// Directed bench for du_dump_serializer: UART/RB/DM models plus per-scenario checking tasks.
module tb_du_dump_serializer;
`ifdef DUMP_CHECKSUM_EN
    localparam int NB_TOTAL = 261;
`else
    localparam int NB_TOTAL = 260;
`endif
    localparam int LOG_N = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] pc;
    logic [31:0] rb_data = '0;
    logic [31:0] dm_data = '0;
    logic        model_done = 1'b0;
    logic        spur_done = 1'b0;
    logic        tx_done;
    logic [4:0]  rb_addr, dm_addr;
    logic        rb_re, dm_re, dm_flag, tx_start, busy, done;
    logic [7:0]  tx_data;
    logic [23:0] outs;

    assign tx_done = model_done | spur_done;
    assign outs = {rb_addr, rb_re, dm_addr, dm_re, dm_flag, tx_data, tx_start, busy, done};

    always #5 clk = ~clk;

    du_dump_serializer dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_pc_value(pc),
        .i_rb_data(rb_data), .i_dm_data(dm_data), .i_tx_done(tx_done),
        .o_rb_addr(rb_addr), .o_rb_read_enable(rb_re), .o_dm_addr(dm_addr),
        .o_dm_read_enable(dm_re), .o_dm_du_flag(dm_flag), .o_tx_data(tx_data),
        .o_tx_start(tx_start), .o_busy(busy), .o_done(done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] byte_log [0:LOG_N-1];
    int start_cyc [0:LOG_N-1];
    int done_cyc  [0:LOG_N-1];
    int rb_re_cyc [0:LOG_N-1];
    logic [4:0] rb_re_addr [0:LOG_N-1];
    int byte_cnt = 0, done_pulses = 0, rb_re_cnt = 0, flag_err = 0, tx_cnt = 0;
    bit zero_data = 1'b0, inj_en = 1'b0;
    bit rb_pend = 1'b0, dm_pend = 1'b0;
    logic [4:0] rb_pend_addr = '0, dm_pend_addr = '0;

    int checks = 0, failures = 0;

    // UART, register bank and data memory models, all evaluated on the falling edge.
    always @(negedge clk) begin
        spur_done  = inj_en && (tx_start || rb_re || dm_re);
        model_done = 1'b0;
        if (rst) begin
            tx_cnt  = 0;
            rb_pend = 1'b0;
            dm_pend = 1'b0;
        end else begin
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    model_done = 1'b1;
                    if (byte_cnt > 0 && byte_cnt <= LOG_N) done_cyc[byte_cnt-1] = cyc;
                end
            end
            if (tx_start) begin
                if (byte_cnt < LOG_N) begin
                    byte_log[byte_cnt]  = tx_data;
                    start_cyc[byte_cnt] = cyc;
                end
                byte_cnt++;
                tx_cnt = 10;
            end
            if (done) done_pulses++;
            if (done && dm_flag) flag_err++;
            if (dm_re && !dm_flag) flag_err++;
            if (rb_re && dm_flag) flag_err++;
            if (rb_re && rb_re_cnt < LOG_N) begin
                rb_re_cyc[rb_re_cnt]  = cyc;
                rb_re_addr[rb_re_cnt] = rb_addr;
                rb_re_cnt++;
            end
            if (rb_pend) rb_data = zero_data ? 32'h0 : 32'h01010101 * 32'(rb_pend_addr);
            if (dm_pend) dm_data = zero_data ? 32'h0 : (32'hA0000000 | 32'(dm_pend_addr));
            rb_pend = rb_re;  rb_pend_addr = rb_addr;
            dm_pend = dm_re;  dm_pend_addr = dm_addr;
        end
    end

    function automatic logic [7:0] exp_byte(input int k, input logic [31:0] pcv, input bit zero);
        int w;
        logic [31:0] word;
        w = k / 4;
        if (w == 0)       word = pcv;
        else if (w <= 32) word = zero ? 32'h0 : 32'h01010101 * 32'(w - 1);
        else              word = zero ? 32'h0 : (32'hA0000000 | 32'(w - 33));
        return 8'(word >> (8 * (k % 4)));
    endfunction

    function automatic int count_bad(input int base, input logic [31:0] pcv, input bit zero);
        int bad = 0;
        logic [7:0] x = '0, e;
        for (int k = 0; k < NB_TOTAL; k++) begin
            e = (k < 260) ? exp_byte(k, pcv, zero) : x;
            x ^= e;
            if (byte_log[base + k] !== e) bad++;
        end
        return bad;
    endfunction

    task automatic pulse_start(output int s);
        @(negedge clk); start = 1'b1; s = cyc;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int base = done_pulses;
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk); #1;
            if (done_pulses > base) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; pc = '0;
        #12;
        checks++;
        if (outs !== 24'h0) begin failures++; $display("FAIL reset_outs got=%h exp=000000", outs); end
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (outs !== 24'h0) begin failures++; $display("FAIL reset_hold got=%h exp=000000", outs); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_full_dump;
        int base = byte_cnt, rbase = rb_re_cnt, dbase = done_pulses, ferr = flag_err, s, bad;
        bit ok;
        logic [31:0] w;
        pc = 32'h12345678;
        pulse_start(s);
        #1;
        checks++;
        if (busy !== 1'b1 || tx_start !== 1'b1) begin
            failures++; $display("FAIL start_busy got busy=%b start=%b exp=1 1", busy, tx_start);
        end
        wait_done(6000, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL full_done_timeout got=0 exp=1"); end
        checks++;
        if (start_cyc[base] !== s + 1) begin
            failures++; $display("FAIL start_latency got=%0d exp=%0d", start_cyc[base] - s, 1);
        end
        w = {byte_log[base+3], byte_log[base+2], byte_log[base+1], byte_log[base]};
        checks++;
        if (w !== 32'h12345678) begin failures++; $display("FAIL pc_bytes got=%h exp=12345678", w); end
        checks++;
        if (byte_cnt - base !== NB_TOTAL) begin
            failures++; $display("FAIL full_count got=%0d exp=%0d", byte_cnt - base, NB_TOTAL);
        end
        w = {byte_log[base+27], byte_log[base+26], byte_log[base+25], byte_log[base+24]};
        checks++;
        if (w !== 32'h05050505) begin failures++; $display("FAIL rb5_bytes got=%h exp=05050505", w); end
        w = {byte_log[base+259], byte_log[base+258], byte_log[base+257], byte_log[base+256]};
        checks++;
        if (w !== 32'hA000001F) begin failures++; $display("FAIL dm31_bytes got=%h exp=a000001f", w); end
        bad = count_bad(base, 32'h12345678, 1'b0);
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL full_stream got=%0d_bad exp=0", bad); end
        checks++;
        if (rb_re_cyc[rbase] !== done_cyc[base+3] + 1 || rb_re_addr[rbase] !== 5'd0) begin
            failures++;
            $display("FAIL boundary_req got=+%0d addr=%0d exp=+1 addr=0",
                     rb_re_cyc[rbase] - done_cyc[base+3], rb_re_addr[rbase]);
        end
        checks++;
        if (start_cyc[base+4] !== done_cyc[base+3] + 3) begin
            failures++;
            $display("FAIL boundary_start got=+%0d exp=+3", start_cyc[base+4] - done_cyc[base+3]);
        end
        checks++;
        if (start_cyc[base+1] !== done_cyc[base] + 1) begin
            failures++;
            $display("FAIL inword_start got=+%0d exp=+1", start_cyc[base+1] - done_cyc[base]);
        end
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (done_pulses - dbase !== 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_once got=%0d busy=%b exp=1 busy=0", done_pulses - dbase, busy);
        end
        checks++;
        if (flag_err !== ferr || dm_flag !== 1'b0) begin
            failures++; $display("FAIL dm_flag got=%0d_err flag=%b exp=0 flag=0", flag_err - ferr, dm_flag);
        end
    endtask

    task automatic test_ignored_inputs;
        int base = byte_cnt, dbase = done_pulses, s, bad;
        bit ok;
        pc = 32'hCAFEF00D;
        inj_en = 1'b1;
        pulse_start(s);
        for (int i = 0; i < 20; i++) begin
            repeat (37) @(negedge clk);
            pulse_start(s);
        end
        wait_done(6000, ok);
        inj_en = 1'b0;
        checks++;
        if (!ok) begin failures++; $display("FAIL noise_done_timeout got=0 exp=1"); end
        checks++;
        if (byte_cnt - base !== NB_TOTAL) begin
            failures++; $display("FAIL noise_count got=%0d exp=%0d", byte_cnt - base, NB_TOTAL);
        end
        bad = count_bad(base, 32'hCAFEF00D, 1'b0);
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL noise_stream got=%0d_bad exp=0", bad); end
        repeat (5) @(negedge clk);
        checks++;
        if (done_pulses - dbase !== 1) begin
            failures++; $display("FAIL noise_done_once got=%0d exp=1", done_pulses - dbase);
        end
    endtask

    task automatic test_reset_mid;
        int base = byte_cnt, s, bad, dsnap, bsnap;
        bit ok = 1'b0;
        pc = 32'h89ABCDEF;
        pulse_start(s);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); #1;
            if (byte_cnt - base >= 100) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL mid_reach100 got=%0d exp=100", byte_cnt - base); end
        dsnap = done_pulses;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (outs !== 24'h0) begin failures++; $display("FAIL mid_async_outs got=%h exp=000000", outs); end
        bsnap = byte_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (done_pulses !== dsnap || byte_cnt !== bsnap || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_abort got=done+%0d bytes+%0d busy=%b exp=0 0 0",
                     done_pulses - dsnap, byte_cnt - bsnap, busy);
        end
        base = byte_cnt;
        pc = 32'h12345678;
        pulse_start(s);
        wait_done(6000, ok);
        checks++;
        if (!ok || byte_log[base] !== 8'h78) begin
            failures++; $display("FAIL restart_first got=%h ok=%b exp=78 ok=1", byte_log[base], ok);
        end
        bad = count_bad(base, 32'h12345678, 1'b0);
        checks++;
        if (byte_cnt - base !== NB_TOTAL || bad !== 0) begin
            failures++;
            $display("FAIL restart_stream got=%0d bytes %0d_bad exp=%0d 0", byte_cnt - base, bad, NB_TOTAL);
        end
    endtask

`ifdef DUMP_CHECKSUM_EN
    task automatic test_checksum;
        int base = byte_cnt, s, bad;
        bit ok;
        zero_data = 1'b1;
        pc = 32'h000000FF;
        pulse_start(s);
        wait_done(6000, ok);
        zero_data = 1'b0;
        checks++;
        if (!ok || byte_cnt - base !== 261) begin
            failures++; $display("FAIL csum_count got=%0d ok=%b exp=261 ok=1", byte_cnt - base, ok);
        end
        checks++;
        if (byte_log[base+260] !== 8'hFF) begin
            failures++; $display("FAIL csum_byte got=%h exp=ff", byte_log[base+260]);
        end
        bad = count_bad(base, 32'h000000FF, 1'b1);
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL csum_stream got=%0d_bad exp=0", bad); end
    endtask
`endif

    initial begin
        test_reset();
        test_full_dump();
        test_ignored_inputs();
        test_reset_mid();
`ifdef DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
